// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: FSM states,
// the $zero register index and the NOP encoding loaded on flush/bubble.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned INSTR_W = 32;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        IMEM_WAIT = 2'd1,
        HALT      = 2'd2
    } state_e;

    localparam logic [REG_W-1:0]   REG_ZERO  = 5'd0;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Ports: clk, reset (async, active-high), inc (count enable),
//        clr (synchronous clear, wins over inc), cnt (current value).
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: drives PC / IF/ID /
// ID/EX enables and flushes, resolving taken branches, imem wait states and
// load-use hazards in that priority. Owns halt state, imem watchdog and
// stall/flush performance counters.
// Ports: clk, reset (async, active-high); ID/EX hazard fields (id_rs, id_rt,
//        id_uses_rt, ex_memread, ex_rt); ex_branch_taken, id_halt, imem_ready;
//        outputs pc_write, if_id_write, if_id_flush, id_ex_bubble (combinational),
//        halted, wd_err, stall_cnt, flush_cnt.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_branch_taken,
    input  logic             id_halt,
    input  logic             imem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             halted,
    output logic             wd_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WCNT_W = $clog2(WAIT_MAX + 1);

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              wd_err_q, wd_err_d;
    logic              stall_inc;
    logic              flush_inc;
    logic              load_use;

    // $zero is never a real dependency, so ex_rt==0 cannot stall.
    assign load_use = ex_memread && (ex_rt != REG_ZERO) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // Next-state, watchdog and pipeline control, highest priority first.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        wd_err_d     = wd_err_q;
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;

        if (reset) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (state_q == HALT) begin
            id_ex_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            // Redirect now; any pending wait restarts on the new fetch.
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_inc    = 1'b1;
            wait_cnt_d   = '0;
            state_d      = imem_ready ? RUN : IMEM_WAIT;
        end else if (!imem_ready) begin
            id_ex_bubble = 1'b1;
            stall_inc    = 1'b1;
            if (wait_cnt_q == WCNT_W'(WAIT_MAX)) begin
                wd_err_d = 1'b1;
                state_d  = HALT;
            end else begin
                wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                state_d    = IMEM_WAIT;
            end
        end else if (load_use) begin
            id_ex_bubble = 1'b1;
            stall_inc    = 1'b1;
            wait_cnt_d   = '0;
            state_d      = RUN;
        end else if (id_halt) begin
            id_ex_bubble = 1'b1;
            wait_cnt_d   = '0;
            state_d      = HALT;
        end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            wait_cnt_d  = '0;
            state_d     = RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            wd_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            wd_err_q   <= wd_err_d;
        end
    end

    assign halted = (state_q == HALT);
    assign wd_err = wd_err_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .clr   (1'b0),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .clr   (1'b0),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: each stimulus cycle pushes its
// expected controls and counters to a scoreboard queue, popped and compared
// on the falling edge.
module tb_pipe_hazard_ctrl;

    localparam int unsigned WAIT_MAX = 4;
    localparam int unsigned CNT_W    = 4;

    // Control vector: {pc_write, if_id_write, if_id_flush, id_ex_bubble, halted, wd_err}
    localparam logic [5:0] C_RUN   = 6'b110000;
    localparam logic [5:0] C_STALL = 6'b000100;
    localparam logic [5:0] C_BR    = 6'b111100;
    localparam logic [5:0] C_RST   = 6'b001100;
    localparam logic [5:0] C_HALT  = 6'b000110;
    localparam logic [5:0] C_WD    = 6'b000111;

    logic             clk;
    logic             reset;
    logic [4:0]       id_rs, id_rt, ex_rt;
    logic             id_uses_rt, ex_memread, ex_branch_taken, id_halt, imem_ready;
    logic             pc_write, if_id_write, if_id_flush, id_ex_bubble, halted, wd_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [5:0]       ctl_obs;

    typedef struct {
        string            tag;
        logic [5:0]       ctl;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
    } exp_t;

    exp_t             sb_q[$];
    int               n_checks = 0;
    int               n_errors = 0;
    logic [CNT_W-1:0] exp_stall = '0;
    logic [CNT_W-1:0] exp_flush = '0;

    pipe_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_memread      (ex_memread),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .id_halt         (id_halt),
        .imem_ready      (imem_ready),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .halted          (halted),
        .wd_err          (wd_err),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    assign ctl_obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, halted, wd_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: compare the oldest expectation mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq({e.tag, ".ctl"},   32'(ctl_obs),   32'(e.ctl));
            check_eq({e.tag, ".stall"}, 32'(stall_cnt), 32'(e.stall));
            check_eq({e.tag, ".flush"}, 32'(flush_cnt), 32'(e.flush));
        end
    end

    // One clock cycle of stimulus; called just after a rising edge.
    task automatic cyc(input string tag, input logic mr, input logic [4:0] ert,
                       input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic br, input logic hlt, input logic rdy,
                       input logic [5:0] ectl, input logic sinc, input logic finc);
        exp_t e;
        ex_memread      = mr;
        ex_rt           = ert;
        id_rs           = rs;
        id_rt           = rt;
        id_uses_rt      = urt;
        ex_branch_taken = br;
        id_halt         = hlt;
        imem_ready      = rdy;
        e.tag   = tag;
        e.ctl   = ectl;
        e.stall = exp_stall;
        e.flush = exp_flush;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sinc && exp_stall != '1) exp_stall = exp_stall + CNT_W'(1);
        if (finc && exp_flush != '1) exp_flush = exp_flush + CNT_W'(1);
    endtask

    task automatic idle(input string tag, input logic rdy, input logic [5:0] ectl, input logic sinc);
        cyc(tag, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, rdy, ectl, sinc, 1'b0);
    endtask

    // Reset pulse applied mid-cycle; forced outputs are checked before any edge.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        check_eq({tag, ".ctl"},   32'(ctl_obs),   32'(C_RST));
        check_eq({tag, ".stall"}, 32'(stall_cnt), 32'd0);
        check_eq({tag, ".flush"}, 32'(flush_cnt), 32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        exp_stall = '0;
        exp_flush = '0;
    endtask

    initial begin
        reset           = 1'b1;
        ex_memread      = 1'b0;
        ex_rt           = 5'd0;
        id_rs           = 5'd0;
        id_rt           = 5'd0;
        id_uses_rt      = 1'b0;
        ex_branch_taken = 1'b0;
        id_halt         = 1'b0;
        imem_ready      = 1'b1;
        #2;
        check_eq("por.ctl",   32'(ctl_obs),   32'(C_RST));
        check_eq("por.stall", 32'(stall_cnt), 32'd0);
        check_eq("por.flush", 32'(flush_cnt), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        idle("run0", 1'b1, C_RUN, 1'b0);
        // Load-use on rs: exactly one stall cycle.
        cyc("lu_rs", 1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, C_STALL, 1'b1, 1'b0);
        idle("lu_rs_after", 1'b1, C_RUN, 1'b0);
        cyc("lu_zero", 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, C_RUN, 1'b0, 1'b0);
        cyc("lu_rt", 1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, C_STALL, 1'b1, 1'b0);
        cyc("lu_rt_unused", 1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, C_RUN, 1'b0, 1'b0);
        cyc("lu_no_load", 1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, C_RUN, 1'b0, 1'b0);
        // Branch beats a simultaneous load-use.
        cyc("br_lu", 1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1, C_BR, 1'b0, 1'b1);
        idle("br_after", 1'b1, C_RUN, 1'b0);
        // Three imem wait cycles then resume.
        for (int i = 0; i < 3; i++) idle("imem_wait", 1'b0, C_STALL, 1'b1);
        idle("imem_resume", 1'b1, C_RUN, 1'b0);
        // Branch mid-wait redirects and restarts the watchdog count.
        idle("bw_wait", 1'b0, C_STALL, 1'b1);
        cyc("bw_branch", 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, C_BR, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) idle("bw_wait2", 1'b0, C_STALL, 1'b1);
        idle("bw_resume", 1'b1, C_RUN, 1'b0);
        // Halt: one bubble cycle, then frozen regardless of inputs.
        cyc("halt_dec", 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1, C_STALL, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) idle("halted", 1'b1, C_HALT, 1'b0);
        cyc("halt_br", 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b1, C_HALT, 1'b0, 1'b0);
        idle("halt_nordy", 1'b0, C_HALT, 1'b0);
        do_reset("rst_halt");

        // Watchdog: WAIT_MAX+1 edges of imem_ready=0 then sticky error.
        idle("wd_run", 1'b1, C_RUN, 1'b0);
        for (int i = 0; i <= int'(WAIT_MAX); i++) idle("wd_wait", 1'b0, C_STALL, 1'b1);
        for (int i = 0; i < 3; i++) idle("wd_trip", 1'b1, C_WD, 1'b0);
        do_reset("rst_wd");

        // Saturation of the stall counter at 4 bits.
        for (int i = 0; i < 20; i++)
            cyc("sat", 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_STALL, 1'b1, 1'b0);
        idle("sat_after", 1'b1, C_RUN, 1'b0);
        do_reset("rst_sat");

        // Reset in IMEM_WAIT with stall_cnt=5; watchdog must restart from zero.
        cyc("pre_lu", 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_STALL, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) idle("pre_wait", 1'b0, C_STALL, 1'b1);
        check_eq("pre_rst.stall", 32'(stall_cnt), 32'd5);
        do_reset("rst_mid");
        for (int i = 0; i < 4; i++) idle("post_wait", 1'b0, C_STALL, 1'b1);
        idle("post_resume", 1'b1, C_RUN, 1'b0);

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It drives the write-enable and flush controls of the PC, the IF/ID register and the ID/EX register, and resolves stalls from three sources: load-use hazards, instruction-memory wait states and taken branches. It also owns the processor halt state, an instruction-memory watchdog and two saturating performance counters. It sits beside the IF/ID and ID/EX registers and is the only block that may stall or flush them.

## Interface
- WAIT_MAX, 16: maximum consecutive cycles with imem_ready=0 before the watchdog trips (≥1)
- CNT_W, 16: width of the performance counters
- clk  in  1  core clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- ex_memread  in  1  instruction in EX is a load
- ex_rt  in  5  destination rt of the instruction in EX
- ex_branch_taken  in  1  branch/jump in EX resolved taken; PC mux selects target this cycle
- id_halt  in  1  ID decodes a halt instruction
- imem_ready  in  1  instruction memory returns valid data this cycle
- pc_write  out  1  PC register load enable
- if_id_write  out  1  IF/ID load enable (0 = hold)
- if_id_flush  out  1  IF/ID loads a NOP (takes precedence over hold)
- id_ex_bubble  out  1  ID/EX loads a NOP in place of ID's decode
- halted  out  1  core halted
- wd_err  out  1  sticky watchdog error
- stall_cnt  out  CNT_W  stall cycles, saturating
- flush_cnt  out  CNT_W  taken-branch flushes, saturating

## Operation
- States: RUN, IMEM_WAIT, HALT. Outputs are combinational from state and inputs. State and counters are registered.
- load_use = ex_memread & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
- Evaluation priority within a cycle, highest first:
  - HALT: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=1, halted=1. The block stays in HALT until reset and ignores all inputs.
  - ex_branch_taken: pc_write=1, if_id_flush=1, id_ex_bubble=1. flush_cnt increments. Next state is RUN if imem_ready, else IMEM_WAIT (wait counter cleared).
  - !imem_ready: pc_write=0, if_id_write=0, id_ex_bubble=1. stall_cnt increments. Next state is IMEM_WAIT.
  - load_use: pc_write=0, if_id_write=0, id_ex_bubble=1. stall_cnt increments. Next state is RUN, so the stall is re-evaluated next cycle.
  - id_halt: pc_write=0, if_id_write=0, id_ex_bubble=1. Next state is HALT.
  - Otherwise: pc_write=1, if_id_write=1, no flush, no bubble. Next state is RUN.
- IMEM_WAIT applies the same priority. A wait counter increments each cycle with imem_ready=0.
  - When the counter reaches WAIT_MAX, wd_err is set (sticky) and the next state is HALT.
  - imem_ready=1 returns the block to RUN in the same cycle's next-state logic, and the normal outputs apply that cycle.
- Counters saturate at all-ones and never wrap. Only the highest-priority cause increments a counter, so at most one counter changes per cycle.
- ex_rt == 0 never causes a stall, because $zero is not a real dependency.

## Timing
- Reset (asynchronous):
  - While reset is asserted: state=RUN, wait counter=0, stall_cnt=0, flush_cnt=0, wd_err=0, halted=0.
  - Forced outputs while reset is asserted: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1.
  - First cycle after deassertion: normal RUN outputs.
- Control latency is 0 cycles: stall and flush decisions apply to the same posedge at which the inputs are sampled.
- A load-use stall lasts exactly 1 cycle. On the next cycle the load is in MEM and ex_memread has dropped.
- Branch flush costs 1 cycle. IF/ID holds a NOP and PC holds the target after the edge.
- Branch and load-use in the same cycle: the branch wins, and the dependent ID instruction is discarded.
- Branch during an imem wait: the PC is redirected immediately, and the wait continues on the new fetch.
- Watchdog: with imem_ready stuck low from a RUN state, wd_err and halted rise after exactly WAIT_MAX+1 edges.
- Reset mid-stall or in HALT: all state clears immediately, with no wait for clk.

## Structure
- Shared package `pipe_ctrl_pkg`:
  - state enum (RUN, IMEM_WAIT, HALT)
  - REG_ZERO = 5'd0
  - NOP encoding = 32'h0000_0000, shared with the IF/ID and ID/EX registers
- One natural sub-module: `sat_counter` (parameter W, inputs inc/clr), instantiated twice for stall_cnt and flush_cnt.
- Everything else lives in one always_ff (state, wait counter, wd_err) plus one always_comb (outputs, next state).

## Test plan
- Reset asserted mid-clock with state=IMEM_WAIT and stall_cnt=5 -> all outputs go to their reset values immediately, stall_cnt=0, state=RUN.
- ex_memread=1, ex_rt=8, id_rs=8 for one cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1 for 1 cycle, stall_cnt=1. Same stimulus with ex_rt=0 -> no stall.
- ex_branch_taken=1 together with a load_use hazard -> if_id_flush=1, pc_write=1, id_ex_bubble=1, flush_cnt=1, stall_cnt=0.
- imem_ready=0 for 3 cycles then 1 -> 3 stall cycles, stall_cnt=3, state back to RUN, pc_write=1 on cycle 4.
- WAIT_MAX=4, imem_ready held 0 -> wd_err=1 and halted=1 after 5 edges. A later imem_ready=1 has no effect until reset.
- id_halt=1 -> HALT from the next edge, pc_write stays 0 for ≥10 cycles. CNT_W=4 with 20 stall cycles -> stall_cnt=15 (saturated).
